// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int BCD_W = 4;

  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] nibble);
    return (nibble >= BCD_W'(5)) ? nibble + BCD_W'(3) : nibble;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done request bus between a requester and the BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                start;
  logic [BIN_W-1:0]    bin_in;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   digit_on;

  modport master (output start, output bin_in,
                  input busy, input done, input bcd_out, input digit_on);
  modport slave  (input start, input bin_in,
                  output busy, output done, output bcd_out, output digit_on);
endinterface

// File: rtl/bcd_add3_cell.sv
// One double-dabble digit corrector: adds 3 to a nibble of 5 or more.
module bcd_add3_cell
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] nib_i,
  output logic [BCD_W-1:0] nib_o
);
  assign nib_o = bcd_add3(nib_i);
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 converter; holds the last result for the seg7 displays.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
)(
  input  logic                    clk,
  input  logic                    reset,
  bin_to_bcd_seq_if.slave         bus
);

  localparam int BCDF_W = BCD_W * DIGITS;
  localparam int SR_W   = BCDF_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  function automatic longint pow10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  if (pow10(DIGITS) <= (longint'(1) << BIN_W) - 1) begin : g_digits_too_few
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end

  state_t              state_q;
  logic [SR_W-1:0]     sr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [BCDF_W-1:0]   bcd_q;
  logic [DIGITS-1:0]   digit_on_q;

  logic [BCD_W-1:0]    nib_adj [DIGITS];
  logic [SR_W-1:0]     sr_adj;
  logic [SR_W-1:0]     sr_d;
  logic [BCDF_W-1:0]   bcd_d;
  logic [DIGITS-1:0]   digit_on_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_add3_cell u_cell (
      .nib_i (sr_q[BIN_W + BCD_W*g +: BCD_W]),
      .nib_o (nib_adj[g])
    );
  end

  always_comb begin
    logic any_nz;
    sr_adj = sr_q;
    for (int k = 0; k < DIGITS; k++) sr_adj[BIN_W + BCD_W*k +: BCD_W] = nib_adj[k];
    sr_d  = {sr_adj[SR_W-2:0], 1'b0};
    bcd_d = sr_d[SR_W-1 -: BCDF_W];
    // A digit is lit once it or any more-significant digit is nonzero.
    any_nz     = 1'b0;
    digit_on_d = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      any_nz        = any_nz | (|bcd_d[BCD_W*k +: BCD_W]);
      digit_on_d[k] = any_nz;
    end
    digit_on_d[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      digit_on_q <= DIGITS'(1);
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            sr_q    <= {{BCDF_W{1'b0}}, bus.bin_in};
            cnt_q   <= CNT_W'(BIN_W);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q - CNT_W'(1);
          // Last shift: publish the result in the same edge that enters DONE.
          if (cnt_q == CNT_W'(1)) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            bcd_q      <= bcd_d;
            digit_on_q <= digit_on_d;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.digit_on = digit_on_q;

endmodule
